// File: rtl/seven_segment_scan_n.sv
// N-digit multiplexed seven-segment scanner: hex/BCD decode, LZ blanking,
// blink, 16-level PWM brightness with ghost guard, double-buffered config.
module seven_segment_scan_n #(
  parameter int NUM_DIGITS       = 8,
  parameter int SUBPHASE_CYCLES  = 1024,
  parameter int BLINK_FRAMES     = 64,
  parameter int HEX_MODE         = 1,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic [3:0]              brightness,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_start,
  output logic                    load_pending
);

  localparam int SW =
    (SUBPHASE_CYCLES > 1) ? $clog2(SUBPHASE_CYCLES) : 1;
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] SUB_LAST = SW'(SUBPHASE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_OFF =
    (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   en;
    logic [NUM_DIGITS-1:0]   blink;
    logic [3:0]              bright;
    logic                    lz;
  } cfg_t;

  logic [SW-1:0]         sub_q, sub_d;
  logic [3:0]            phase_q, phase_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         blk_cnt_q, blk_cnt_d;
  logic                  blink_q, blink_d;
  cfg_t                  shadow_q, shadow_d;
  cfg_t                  active_q, active_d;
  cfg_t                  in_cfg;
  logic                  pend_q, pend_d;
  logic                  fs_q, fs_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  sub_wrap;
  logic                  ph_wrap;
  logic                  idx_wrap;
  logic                  boundary;
  logic                  apply;

  logic [3:0]            nib;
  logic                  en_b;
  logic                  bl_b;
  logic                  dp_b;
  logic                  lz_b;
  logic [NUM_DIGITS-1:0] oh;
  logic [NUM_DIGITS-1:0] lzv;
  logic                  zero_above;
  logic                  nz;
  logic [6:0]            dec;
  logic                  lit;

  // Scan counters
  always_comb begin
    sub_wrap = (sub_q == SUB_LAST);
    ph_wrap  = sub_wrap && (phase_q == 4'hF);
    idx_wrap = ph_wrap && (idx_q == IDX_LAST);
    boundary = (sub_q == '0) && (phase_q == 4'h0) &&
               (idx_q == '0);
    sub_d    = sub_wrap ? '0 : sub_q + SW'(1);
    phase_d  = sub_wrap ? phase_q + 4'd1 : phase_q;
    idx_d    = idx_q;
    if (ph_wrap) begin
      idx_d = idx_wrap ? '0 : idx_q + IW'(1);
    end
  end

  // Blink phase flips on the last cycle of a frame so the new
  // value is already in place on the boundary cycle.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    blink_d   = blink_q;
    if (idx_wrap) begin
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d = '0;
        blink_d   = ~blink_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BW'(1);
      end
    end
  end

  always_comb begin
    in_cfg.digits = digits;
    in_cfg.dp     = dp;
    in_cfg.en     = digit_en;
    in_cfg.blink  = blink_en;
    in_cfg.bright = brightness;
    in_cfg.lz     = lz_blank;
  end

  // The boundary cycle already renders from the freshly applied
  // config, so the first output of a frame is never torn.
  always_comb begin
    apply    = boundary && pend_q;
    shadow_d = load ? in_cfg : shadow_q;
    active_d = apply ? shadow_q : active_q;
    pend_d   = load || (pend_q && !boundary);
    fs_d     = boundary;
  end

  always_comb begin
    lzv        = '0;
    zero_above = 1'b1;
    nz         = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nz = (active_d.digits[4*k +: 4] != 4'h0);
      lzv[k] = active_d.lz && (k != 0) && !nz && zero_above;
      if (active_d.en[k] && nz) begin
        zero_above = 1'b0;
      end
    end
  end

  always_comb begin
    nib  = 4'h0;
    en_b = 1'b0;
    bl_b = 1'b0;
    dp_b = 1'b0;
    lz_b = 1'b0;
    oh   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib   = active_d.digits[4*k +: 4];
        en_b  = active_d.en[k];
        bl_b  = active_d.blink[k];
        dp_b  = active_d.dp[k];
        lz_b  = lzv[k];
        oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    dec = 7'h00;
    unique case (nib)
      4'h0: dec = 7'b0111111;
      4'h1: dec = 7'b0000110;
      4'h2: dec = 7'b1011011;
      4'h3: dec = 7'b1001111;
      4'h4: dec = 7'b1100110;
      4'h5: dec = 7'b1101101;
      4'h6: dec = 7'b1111101;
      4'h7: dec = 7'b0000111;
      4'h8: dec = 7'b1111111;
      4'h9: dec = 7'b1101111;
      4'hA: dec = 7'b1110111;
      4'hB: dec = 7'b1111100;
      4'hC: dec = 7'b0111001;
      4'hD: dec = 7'b1011110;
      4'hE: dec = 7'b1111001;
      4'hF: dec = 7'b1110001;
    endcase
    if ((HEX_MODE == 0) && (nib > 4'd9)) begin
      dec = 7'h00;
    end
  end

  // Phase 15 never satisfies phase < brightness: inter-digit guard.
  always_comb begin
    lit = en_b && !lz_b && !(blink_q && bl_b) &&
          (phase_q < active_d.bright);
    an_d  = lit ? (oh ^ AN_OFF) : AN_OFF;
    seg_d = lit ? (dec ^ SEG_OFF) : SEG_OFF;
    dp_d  = (lit && dp_b) ^ DP_OFF;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sub_q     <= '0;
      phase_q   <= 4'h0;
      idx_q     <= '0;
      blk_cnt_q <= '0;
      blink_q   <= 1'b0;
      shadow_q  <= '0;
      active_q  <= '0;
      pend_q    <= 1'b0;
      fs_q      <= 1'b0;
      seg_q     <= SEG_OFF;
      dp_q      <= DP_OFF;
      an_q      <= AN_OFF;
    end else begin
      sub_q     <= sub_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      blk_cnt_q <= blk_cnt_d;
      blink_q   <= blink_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      fs_q      <= fs_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign seg          = seg_q;
  assign dp_out       = dp_q;
  assign anode        = an_q;
  assign frame_start  = fs_q;
  assign load_pending = pend_q;

endmodule

// File: tb/tb_seven_segment_scan_n.sv
// Bench for seven_segment_scan_n: 4 digits, 2-cycle sub-phase,
// 2-frame blink, active-low anodes and segments.
module tb_seven_segment_scan_n;

  logic        clk;
  logic        resetn;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic [3:0]  blink_en;
  logic [3:0]  brightness;
  logic        lz_blank;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  anode;
  logic        frame_start;
  logic        load_pending;

  seven_segment_scan_n #(
    .NUM_DIGITS(4),
    .SUBPHASE_CYCLES(2),
    .BLINK_FRAMES(2),
    .HEX_MODE(1),
    .ANODE_ACTIVE_LOW(1),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .load(load),
    .digits(digits),
    .dp(dp),
    .digit_en(digit_en),
    .blink_en(blink_en),
    .brightness(brightness),
    .lz_blank(lz_blank),
    .seg(seg),
    .dp_out(dp_out),
    .anode(anode),
    .frame_start(frame_start),
    .load_pending(load_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      digits;
    logic [3:0]       dp;
    logic [3:0]       en;
    logic [3:0]       blink;
    logic [3:0]       bright;
    logic             lz;
    logic [3:0][6:0]  eseg;
    logic [3:0][5:0]  eon;
  } vec_t;

  vec_t tv [8];
  vec_t dark;
  vec_t v2;
  vec_t v3;
  vec_t vb;

  int p;
  int total;
  int bad;

  function automatic vec_t mk(
    input logic [15:0] d, input logic [3:0] pdp,
    input logic [3:0] en, input logic [3:0] bl,
    input logic [3:0] br, input logic lz,
    input logic [27:0] es, input logic [23:0] eo);
    vec_t r;
    r.digits = d;
    r.dp     = pdp;
    r.en     = en;
    r.blink  = bl;
    r.bright = br;
    r.lz     = lz;
    r.eseg   = es;
    r.eon    = eo;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    p++;
  endtask

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (p=%0d)",
               nm, act, exp, p);
    end
  endtask

  task automatic set_cfg(input vec_t v);
    digits     = v.digits;
    dp         = v.dp;
    digit_en   = v.en;
    blink_en   = v.blink;
    brightness = v.bright;
    lz_blank   = v.lz;
  endtask

  // Checks one full frame; expects p%128==127 on entry.
  task automatic check_frame(input vec_t v,
                             input int l1, input logic [15:0] d1,
                             input int l2, input logic [15:0] d2);
    logic        bl;
    logic        lit;
    logic [3:0]  one;
    logic [12:0] act;
    logic [12:0] exp;
    logic [12:0] fa;
    logic [12:0] fe;
    int          n;
    int          errs;
    bl = (((p + 1) / 256) % 2) == 1;
    n  = 0;
    for (int d = 0; d < 4; d++) begin
      errs = 0;
      fa   = '0;
      fe   = '0;
      for (int o = 0; o < 32; o++) begin
        load = 1'b0;
        if (n == l1) begin
          digits = d1;
          load   = 1'b1;
        end
        if (n == l2) begin
          digits = d2;
          load   = 1'b1;
        end
        tick();
        n++;
        lit = (o < int'(v.eon[d])) && !(bl && v.blink[d]);
        one = 4'b0001 << d;
        exp = {lit ? ~one : 4'hF,
               lit ? v.eseg[d] : 7'h7F,
               lit ? ~v.dp[d] : 1'b1,
               (d == 0) && (o == 0)};
        act = {anode, seg, dp_out, frame_start};
        if (act !== exp) begin
          if (errs == 0) begin
            fa = act;
            fe = exp;
          end
          errs++;
        end
      end
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL slot%0d frame%0d: got %h want %h (%0d cycles)",
                 d, p / 128, fa, fe, errs);
      end
    end
    load = 1'b0;
  endtask

  task automatic load_vec(input vec_t v);
    while (p % 128 != 49) tick();
    set_cfg(v);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("pend_set", 16'(load_pending), 16'h1);
    while (p % 128 != 127) tick();
    chk("pend_hold", 16'(load_pending), 16'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    total  = 0;
    bad    = 0;
    p      = -1;
    resetn = 1'b0;
    load   = 1'b0;
    digits = '0;
    dp = '0; digit_en = '0; blink_en = '0;
    brightness = '0; lz_blank = 1'b0;

    dark = mk(16'h0, 4'h0, 4'h0, 4'h0, 4'd0, 1'b0,
              {4{7'h7F}}, 24'd0);
    tv[0] = mk(16'h12AF, 4'h0, 4'hF, 4'h0, 4'd15, 1'b0,
               {7'h79, 7'h24, 7'h08, 7'h0E}, {4{6'd30}});
    tv[1] = mk(16'h12AF, 4'h2, 4'hF, 4'h0, 4'd4, 1'b0,
               {7'h79, 7'h24, 7'h08, 7'h0E}, {4{6'd8}});
    tv[2] = mk(16'h12AF, 4'hF, 4'hF, 4'h0, 4'd0, 1'b0,
               {7'h79, 7'h24, 7'h08, 7'h0E}, {4{6'd0}});
    tv[3] = mk(16'h0070, 4'h0, 4'hF, 4'h0, 4'd15, 1'b1,
               {7'h7F, 7'h7F, 7'h78, 7'h40},
               {6'd0, 6'd0, 6'd30, 6'd30});
    tv[4] = mk(16'h0070, 4'h0, 4'hA, 4'h0, 4'd15, 1'b0,
               {7'h40, 7'h7F, 7'h78, 7'h7F},
               {6'd30, 6'd0, 6'd30, 6'd0});
    tv[5] = mk(16'h5030, 4'h0, 4'h6, 4'h0, 4'd15, 1'b1,
               {7'h7F, 7'h7F, 7'h30, 7'h7F},
               {6'd0, 6'd0, 6'd30, 6'd0});
    tv[6] = mk(16'h1008, 4'h0, 4'hF, 4'h0, 4'd15, 1'b1,
               {7'h79, 7'h40, 7'h40, 7'h00}, {4{6'd30}});
    tv[7] = mk(16'hBCDE, 4'hF, 4'hF, 4'h0, 4'd1, 1'b0,
               {7'h03, 7'h46, 7'h21, 7'h06}, {4{6'd2}});
    v2 = mk(16'h2222, 4'h0, 4'hF, 4'h0, 4'd15, 1'b0,
            {4{7'h24}}, {4{6'd30}});
    v3 = mk(16'h3333, 4'h0, 4'hF, 4'h0, 4'd15, 1'b0,
            {4{7'h30}}, {4{6'd30}});
    vb = mk(16'h12AF, 4'h1, 4'hF, 4'h1, 4'd15, 1'b0,
            {7'h79, 7'h24, 7'h08, 7'h0E}, {4{6'd30}});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_anode", 16'(anode), 16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp", 16'(dp_out), 16'h1);
    chk("rst_fs", 16'(frame_start), 16'h0);
    chk("rst_pend", 16'(load_pending), 16'h0);
    resetn = 1'b1;

    for (int f = 0; f < 3; f++) check_frame(dark, -1, 0, -1, 0);

    for (int i = 0; i < 8; i++) begin
      load_vec(tv[i]);
      check_frame(tv[i], -1, 0, -1, 0);
      chk("pend_clr", 16'(load_pending), 16'h0);
    end

    // Two loads mid-frame, then one on the boundary cycle
    set_cfg(v2);
    digits = 16'h1111;
    check_frame(tv[7], 20, 16'h1111, 60, 16'h2222);
    chk("multi_pend", 16'(load_pending), 16'h1);
    check_frame(v2, 0, 16'h3333, -1, 0);
    chk("bnd_pend", 16'(load_pending), 16'h1);
    check_frame(v3, -1, 0, -1, 0);
    chk("bnd_clr", 16'(load_pending), 16'h0);

    load_vec(vb);
    for (int f = 0; f < 4; f++) check_frame(vb, -1, 0, -1, 0);

    // Asynchronous reset in the middle of a lit slot
    while (p % 128 != 37) tick();
    chk("pre_rst_an", 16'(anode), 16'hD);
    digits = 16'h8888;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    chk("pre_rst_pend", 16'(load_pending), 16'h1);
    resetn = 1'b0;
    #1;
    chk("arst_anode", 16'(anode), 16'hF);
    chk("arst_seg", 16'(seg), 16'h7F);
    chk("arst_dp", 16'(dp_out), 16'h1);
    chk("arst_pend", 16'(load_pending), 16'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    p = -1;
    check_frame(dark, -1, 0, -1, 0);
    chk("post_rst_pend", 16'(load_pending), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
